// File: rtl/vxe_cu_dispatch_sched_pkg.sv
// Shared CU control package: dispatch scheduler state encoding and the
// default command opcode / payload widths used by the CU control blocks.
package vxe_cu_dispatch_sched_pkg;

  // Default command field widths.
  localparam int CU_OPW = 5;
  localparam int CU_DW  = 56;

  // Dispatch scheduler states.
  localparam logic [1:0] ST_IDLE   = 2'd0;  // no command held
  localparam logic [1:0] ST_ISSUE  = 2'd1;  // command held, pending mask non-zero
  localparam logic [1:0] ST_HALTED = 2'd2;  // halted by the CU execute unit

endpackage

// File: rtl/vxe_cu_dispatch_hold.sv
// Command holding register plus per-VPU pending mask.
// Ports:
//   clk, nrst   : clock, asynchronous active-low reset
//   i_load      : latch i_op/i_data and load the pending mask from i_dst
//   i_op/i_data : command fields to latch
//   i_dst       : target mask loaded into the pending mask
//   i_accept    : per-VPU accept (valid & ready); clears pending bits
//   o_op/o_data : held command, stable until the next load
//   o_pend      : pending mask (VPUs that still owe an accept)
//   o_drain     : all pending bits are clear after this edge
module vxe_cu_dispatch_hold
  import vxe_cu_dispatch_sched_pkg::*;
#(
  parameter int VPUS_NR = 2,
  parameter int OPW     = CU_OPW,
  parameter int DW      = CU_DW
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               i_load,
  input  logic [OPW-1:0]     i_op,
  input  logic [DW-1:0]      i_data,
  input  logic [VPUS_NR-1:0] i_dst,
  input  logic [VPUS_NR-1:0] i_accept,
  output logic [OPW-1:0]     o_op,
  output logic [DW-1:0]      o_data,
  output logic [VPUS_NR-1:0] o_pend,
  output logic               o_drain
);

  logic [OPW-1:0]     r_op;
  logic [DW-1:0]      r_data;
  logic [VPUS_NR-1:0] r_pend;

  // Holding register and pending mask; a load replaces the whole command,
  // otherwise accepted VPUs drop out of the pending mask.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_op   <= {OPW{1'b0}};
      r_data <= {DW{1'b0}};
      r_pend <= {VPUS_NR{1'b0}};
    end else if (i_load) begin
      r_op   <= i_op;
      r_data <= i_data;
      r_pend <= i_dst;
    end else begin
      r_pend <= r_pend & ~i_accept;
    end
  end

  assign o_op    = r_op;
  assign o_data  = r_data;
  assign o_pend  = r_pend;
  assign o_drain = ((r_pend & ~i_accept) == {VPUS_NR{1'b0}});

endmodule

// File: rtl/vxe_cu_dispatch_sched.sv
// CU dispatch scheduler: takes one decoded command at a time and broadcasts
// it to the VPUs named in its target mask; each VPU accepts independently.
// Supports halt/unhalt from the CU execute unit (held command drains first).
// Ports:
//   clk, nrst                       : clock, asynchronous active-low reset
//   i_halt / i_unhalt               : halt / resume requests
//   i_cmd_valid / o_cmd_rdy         : command handshake
//   i_cmd_op, i_cmd_data, i_cmd_dst : command opcode, payload, target mask
//   o_vpu_valid / i_vpu_rdy         : per-VPU handshake
//   o_vpu_op, o_vpu_data            : shared command bus to all VPUs
//   o_pipes_active                  : a command is held
//   o_halted                        : scheduler is halted
//   o_err                           : one-cycle pulse after a zero-mask command
module vxe_cu_dispatch_sched
  import vxe_cu_dispatch_sched_pkg::*;
#(
  parameter int VPUS_NR = 2,
  parameter int OPW     = CU_OPW,
  parameter int DW      = CU_DW
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               i_halt,
  input  logic               i_unhalt,
  input  logic               i_cmd_valid,
  output logic               o_cmd_rdy,
  input  logic [OPW-1:0]     i_cmd_op,
  input  logic [DW-1:0]      i_cmd_data,
  input  logic [VPUS_NR-1:0] i_cmd_dst,
  output logic [VPUS_NR-1:0] o_vpu_valid,
  input  logic [VPUS_NR-1:0] i_vpu_rdy,
  output logic [OPW-1:0]     o_vpu_op,
  output logic [DW-1:0]      o_vpu_data,
  output logic               o_pipes_active,
  output logic               o_halted,
  output logic               o_err
);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic               r_halt_pend;
  logic               w_halt_pend_nxt;
  logic               r_rst_done;
  logic               r_err;
  logic [VPUS_NR-1:0] w_pend;
  logic [VPUS_NR-1:0] w_accept;
  logic               w_drain;
  logic               w_rdy;
  logic               w_xfer;
  logic               w_zero;
  logic               w_load;
  logic               w_halt_eff;

  assign o_vpu_valid = (r_state == ST_ISSUE) ? w_pend : {VPUS_NR{1'b0}};
  assign w_accept    = o_vpu_valid & i_vpu_rdy;
  assign w_xfer      = i_cmd_valid & w_rdy;
  assign w_zero      = (i_cmd_dst == {VPUS_NR{1'b0}});
  assign w_load      = w_xfer & ~w_zero;
  // Halt wins over a simultaneous unhalt.
  assign w_halt_eff  = i_halt | (~i_unhalt & r_halt_pend);

  vxe_cu_dispatch_hold #(
    .VPUS_NR(VPUS_NR),
    .OPW    (OPW),
    .DW     (DW)
  ) u_hold (
    .clk     (clk),
    .nrst    (nrst),
    .i_load  (w_load),
    .i_op    (i_cmd_op),
    .i_data  (i_cmd_data),
    .i_dst   (i_cmd_dst),
    .i_accept(w_accept),
    .o_op    (o_vpu_op),
    .o_data  (o_vpu_data),
    .o_pend  (w_pend),
    .o_drain (w_drain)
  );

  // Command-ready: i_halt blocks the same cycle; in ISSUE only when the held
  // command retires this edge, which gives back-to-back issue.
  always_comb begin
    w_rdy = 1'b0;
    if (r_rst_done && !r_halt_pend && !i_halt) begin
      case (r_state)
        ST_IDLE:  w_rdy = 1'b1;
        ST_ISSUE: w_rdy = w_drain;
        default:  w_rdy = 1'b0;
      endcase
    end else begin
      w_rdy = 1'b0;
    end
  end

  // Next-state and halt-pending flag; entering HALTED consumes the flag.
  always_comb begin
    w_state_nxt     = r_state;
    w_halt_pend_nxt = w_halt_eff;
    case (r_state)
      ST_IDLE: begin
        if (w_load) begin
          w_state_nxt = ST_ISSUE;
        end else if (w_halt_eff) begin
          w_state_nxt     = ST_HALTED;
          w_halt_pend_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!w_drain) begin
          w_state_nxt = ST_ISSUE;
        end else if (w_load) begin
          w_state_nxt = ST_ISSUE;
        end else if (w_halt_eff) begin
          w_state_nxt     = ST_HALTED;
          w_halt_pend_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HALTED: begin
        w_halt_pend_nxt = 1'b0;
        if (i_unhalt && !i_halt) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_HALTED;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_halt_pend_nxt = 1'b0;
      end
    endcase
  end

  // Control registers; r_rst_done keeps o_cmd_rdy low until the first edge
  // after reset release.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= ST_IDLE;
      r_halt_pend <= 1'b0;
      r_rst_done  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_halt_pend <= w_halt_pend_nxt;
      r_rst_done  <= 1'b1;
      r_err       <= w_xfer & w_zero;
    end
  end

  assign o_cmd_rdy      = w_rdy;
  assign o_pipes_active = (r_state == ST_ISSUE);
  assign o_halted       = (r_state == ST_HALTED);
  assign o_err          = r_err;

endmodule

// File: tb/tb_vxe_cu_dispatch_sched.sv
module tb_vxe_cu_dispatch_sched;

  logic        clk;
  logic        nrst;
  logic        i_halt;
  logic        i_unhalt;
  logic        i_cmd_valid;
  logic        o_cmd_rdy;
  logic [4:0]  i_cmd_op;
  logic [55:0] i_cmd_data;
  logic [1:0]  i_cmd_dst;
  logic [1:0]  o_vpu_valid;
  logic [1:0]  i_vpu_rdy;
  logic [4:0]  o_vpu_op;
  logic [55:0] o_vpu_data;
  logic        o_pipes_active;
  logic        o_halted;
  logic        o_err;

  vxe_cu_dispatch_sched #(.VPUS_NR(2), .OPW(5), .DW(56)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .i_halt        (i_halt),
    .i_unhalt      (i_unhalt),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_rdy     (o_cmd_rdy),
    .i_cmd_op      (i_cmd_op),
    .i_cmd_data    (i_cmd_data),
    .i_cmd_dst     (i_cmd_dst),
    .o_vpu_valid   (o_vpu_valid),
    .i_vpu_rdy     (i_vpu_rdy),
    .o_vpu_op      (o_vpu_op),
    .o_vpu_data    (o_vpu_data),
    .o_pipes_active(o_pipes_active),
    .o_halted      (o_halted),
    .o_err         (o_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard: per-VPU queue of commands still owed to that VPU, plus a
  // queue of expected error pulses.
  logic [60:0] exp_q [2][$];
  int          err_q [$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  // Reference model of the halt / reset status.
  bit m_halted    = 1'b0;
  bit m_halt_pend = 1'b0;
  bit m_rst_done  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check status outputs, record any
  // accepted command, then advance the model past the coming edge.
  task automatic cycle(input logic v, input logic [4:0] op, input logic [55:0] data,
                       input logic [1:0] dst, input logic [1:0] rdy,
                       input logic h, input logic u);
    logic [1:0] owed;
    logic       busy, retire, exp_rdy, xfer, heff;
    @(negedge clk);
    i_cmd_valid = v; i_cmd_op = op; i_cmd_data = data; i_cmd_dst = dst;
    i_vpu_rdy = rdy; i_halt = h; i_unhalt = u;
    #2;
    for (int k = 0; k < 2; k++) owed[k] = (exp_q[k].size() != 0);
    busy    = (owed != 2'b00);
    retire  = ((owed & ~rdy) == 2'b00);
    exp_rdy = m_rst_done && !m_halted && !m_halt_pend && !h && retire;
    chk("cmd_rdy", {63'd0, o_cmd_rdy}, {63'd0, exp_rdy});
    chk("vpu_valid", {62'd0, o_vpu_valid}, {62'd0, owed});
    chk("pipes_active", {63'd0, o_pipes_active}, {63'd0, busy});
    chk("halted", {63'd0, o_halted}, {63'd0, m_halted});
    for (int k = 0; k < 2; k++)
      if (owed[k]) chk("bus_stable", {3'd0, o_vpu_op, o_vpu_data}, {3'd0, exp_q[k][0]});
    xfer = v && exp_rdy;
    if (xfer && dst != 2'b00) begin
      for (int k = 0; k < 2; k++) if (dst[k]) exp_q[k].push_back({op, data});
    end else if (xfer) begin
      err_q.push_back(1);
    end
    m_rst_done = 1'b1;
    if (m_halted) begin
      if (u && !h) m_halted = 1'b0;
    end else begin
      heff = h ? 1'b1 : (u ? 1'b0 : m_halt_pend);
      if (xfer && dst != 2'b00) begin
        m_halt_pend = heff;
      end else if ((!busy || retire) && heff) begin
        m_halted    = 1'b1;
        m_halt_pend = 1'b0;
      end else begin
        m_halt_pend = heff;
      end
    end
  endtask

  task automatic idle(input logic [1:0] rdy);
    cycle(1'b0, 5'd0, 56'd0, 2'b00, rdy, 1'b0, 1'b0);
  endtask

  // Reset for two cycles, then release with a command offered: it must not
  // be taken before the first edge after release.
  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    i_cmd_valid = 1'b1; i_cmd_dst = 2'b11; i_vpu_rdy = 2'b11; i_halt = 1'b0; i_unhalt = 1'b0;
    for (int k = 0; k < 2; k++) exp_q[k].delete();
    err_q.delete();
    m_halted = 1'b0; m_halt_pend = 1'b0; m_rst_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        @(negedge clk);
        nrst = 1'b1;
      end else if (c == 1) begin
        @(negedge clk);
      end
      #2;
      chk("rst_cmd_rdy", {63'd0, o_cmd_rdy}, 64'd0);
      chk("rst_vpu_valid", {62'd0, o_vpu_valid}, 64'd0);
      chk("rst_pipes", {63'd0, o_pipes_active}, 64'd0);
      chk("rst_halted", {63'd0, o_halted}, 64'd0);
      chk("rst_err", {63'd0, o_err}, 64'd0);
    end
    i_cmd_valid = 1'b0;
    m_rst_done = 1'b1;
  endtask

  // Monitor: pops and compares each per-VPU delivery and each error pulse.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      for (int k = 0; k < 2; k++) begin
        if (o_vpu_valid[k] && i_vpu_rdy[k]) begin
          if (exp_q[k].size() == 0) begin
            chk("unexpected_delivery", {63'd0, 1'b1}, 64'd0);
          end else begin
            chk("delivery", {3'd0, o_vpu_op, o_vpu_data}, {3'd0, exp_q[k].pop_front()});
          end
        end
      end
      if (o_err) begin
        chk("err_expected", {63'd0, (err_q.size() != 0)}, 64'd1);
        if (err_q.size() != 0) void'(err_q.pop_front());
      end
    end
  end

  initial begin
    logic [63:0] r64;
    nrst = 1'b0;
    i_halt = 1'b0; i_unhalt = 1'b0; i_cmd_valid = 1'b0;
    i_cmd_op = 5'd0; i_cmd_data = 56'd0; i_cmd_dst = 2'b00; i_vpu_rdy = 2'b00;
    do_reset();

    // Broadcast to both VPUs, both ready.
    cycle(1'b1, 5'd5, 56'hA5A5_0000_1234, 2'b11, 2'b11, 1'b0, 1'b0);
    idle(2'b11);
    idle(2'b11);
    // Staggered accept.
    cycle(1'b1, 5'd9, 56'h00C0_FFEE_0042, 2'b11, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle(2'b01);
    idle(2'b10);
    idle(2'b00);
    // Back-to-back to VPU0.
    for (int i = 0; i < 4; i++) cycle(1'b1, 5'(i + 1), 56'(i * 17), 2'b01, 2'b01, 1'b0, 1'b0);
    idle(2'b01);
    // Halt while a command is stalled, then drain, then unhalt.
    cycle(1'b1, 5'd3, 56'h33, 2'b11, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 5'd4, 56'h44, 2'b11, 2'b00, 1'b1, 1'b0);
    cycle(1'b1, 5'd4, 56'h44, 2'b11, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 5'd4, 56'h44, 2'b11, 2'b11, 1'b0, 1'b0);
    idle(2'b11);
    cycle(1'b0, 5'd0, 56'd0, 2'b00, 2'b11, 1'b0, 1'b1);
    idle(2'b11);
    // Zero-mask command, then simultaneous halt and unhalt.
    cycle(1'b1, 5'd7, 56'h77, 2'b00, 2'b11, 1'b0, 1'b0);
    idle(2'b11);
    cycle(1'b0, 5'd0, 56'd0, 2'b00, 2'b11, 1'b1, 1'b1);
    idle(2'b11);
    cycle(1'b0, 5'd0, 56'd0, 2'b00, 2'b11, 1'b0, 1'b1);
    idle(2'b11);
    // Reset while VPU1 still owes an accept.
    cycle(1'b1, 5'd2, 56'h22, 2'b10, 2'b00, 1'b0, 1'b0);
    idle(2'b00);
    do_reset();
    for (int i = 0; i < 3; i++) idle(2'b11);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r64 = {$urandom(), $urandom()};
      cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), r64[55:0],
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 24) == 0, $urandom_range(0, 7) == 0);
      if (i == 1500) do_reset();
    end

    // Drain everything and leave halt.
    for (int i = 0; i < 6; i++) cycle(1'b0, 5'd0, 56'd0, 2'b00, 2'b11, 1'b0, 1'b1);
    idle(2'b11);
    chk("vpu0_all_delivered", 64'(exp_q[0].size()), 64'd0);
    chk("vpu1_all_delivered", 64'(exp_q[1].size()), 64'd0);
    chk("err_all_seen", 64'(err_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
